multiplier_slot_scheduler: RTL and testbench

Shares one Multiplier_Pipeline thread-slotted multiplier between REQUESTER_COUNT non-threaded requesters, such as accelerators or I/O engines. Each cycle it arbitrates pending requests onto the next free pipeline slot and drives that slot's config, A and B writes. It tracks every in-flight operation by tag and returns results through a credit-protected FIFO with valid/ready backpressure. It sits between the requesters and the multiplier's write/result ports; slots not released by the processor stay untouched.

---
 rtl/multiplier_slot_scheduler.sv | 139 +++++++++++++
 tb/tb_multiplier_slot_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_slot_scheduler.sv
// multiplier_slot_scheduler: shares a thread-slotted multiplier between requesters and returns tagged results.
// Define MULT_SCHED_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requester index wins.
module multiplier_slot_scheduler #(
    parameter int WORD_WIDTH        = 36,
    parameter int THREAD_COUNT      = 8,
    parameter int REQUESTER_COUNT   = 4,
    parameter int RESULT_LATENCY    = 16,
    parameter int FIFO_DEPTH        = 8,
    parameter int CONFIG_ADDR       = 0,
    parameter int CONFIG_ADDR_WIDTH = 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [THREAD_COUNT-1:0]               slot_mask,
    input  logic [REQUESTER_COUNT-1:0]            req_valid,
    output logic [REQUESTER_COUNT-1:0]            req_ready,
    input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_A,
    input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_B,
    input  logic [REQUESTER_COUNT-1:0]            req_signed,
    output logic [CONFIG_ADDR_WIDTH-1:0]          mul_config_addr,
    output logic                                  mul_config_signed,
    output logic                                  mul_config_enable,
    output logic [WORD_WIDTH-1:0]                 mul_A,
    output logic [WORD_WIDTH-1:0]                 mul_B,
    output logic                                  mul_A_wren,
    output logic                                  mul_B_wren,
    input  logic [WORD_WIDTH-1:0]                 mul_R_low,
    input  logic [WORD_WIDTH-1:0]                 mul_R_high,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [$clog2(REQUESTER_COUNT)-1:0]    res_tag,
    output logic [WORD_WIDTH-1:0]                 res_low,
    output logic [WORD_WIDTH-1:0]                 res_high
);
    localparam int SW = $clog2(THREAD_COUNT);
    localparam int TW = $clog2(REQUESTER_COUNT);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam int EW = TW + 2 * WORD_WIDTH;

    logic [SW-1:0]         slot_q, next_slot;
    logic [WORD_WIDTH-1:0] a_q, b_q;
    logic                  sgn_q, wr_q, found, credit, grant, cap, pop;
    logic [TW-1:0]         tag_q, win;
    logic [CW-1:0]         in_flight_q, in_flight_d, fifo_count_q, fifo_count_d;
    logic [CW:0]           used;
    logic [FW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [TW:0]           trk_q [RESULT_LATENCY];
    logic [EW-1:0]         mem_q [FIFO_DEPTH];

`ifdef MULT_SCHED_ROUND_ROBIN_EN
    logic [TW-1:0] ptr_q, ptr_d;
    always_comb begin
        logic [TW-1:0] idx;
        idx = '0;
        win = '0;
        found = 1'b0;
        for (int k = 0; k < REQUESTER_COUNT; k++) begin
            idx = TW'((int'(ptr_q) + k) % REQUESTER_COUNT);
            if (!found && req_valid[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end
    assign ptr_d = grant ? TW'((int'(win) + 1) % REQUESTER_COUNT) : ptr_q;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
`else
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int k = REQUESTER_COUNT - 1; k >= 0; k--)
            if (req_valid[TW'(k)]) begin
                win = TW'(k);
                found = 1'b1;
            end
    end
`endif

    // Credit counts granted-but-uncaptured ops so a capture can never find the FIFO full.
    assign next_slot    = slot_q + 1'b1;
    assign used         = {1'b0, fifo_count_q} + {1'b0, in_flight_q};
    assign credit       = used < (CW+1)'(FIFO_DEPTH);
    assign grant        = reset_n & found & slot_mask[next_slot] & credit;
    assign req_ready    = grant ? REQUESTER_COUNT'(1) << win : '0;
    assign cap          = trk_q[RESULT_LATENCY-1][TW];
    assign res_valid    = fifo_count_q != '0;
    assign pop          = res_valid & res_ready;
    assign in_flight_d  = in_flight_q + CW'(grant) - CW'(cap);
    assign fifo_count_d = fifo_count_q + CW'(cap) - CW'(pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sgn_q        <= 1'b0;
            wr_q         <= 1'b0;
            tag_q        <= '0;
            in_flight_q  <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < RESULT_LATENCY; i++) trk_q[i] <= '0;
        end else begin
            slot_q <= next_slot;
            wr_q   <= grant;
            if (grant) begin
                a_q   <= WORD_WIDTH'(req_A >> (int'(win) * WORD_WIDTH));
                b_q   <= WORD_WIDTH'(req_B >> (int'(win) * WORD_WIDTH));
                sgn_q <= req_signed[win];
                tag_q <= win;
            end
            trk_q[0] <= {wr_q, tag_q};
            for (int i = 1; i < RESULT_LATENCY; i++) trk_q[i] <= trk_q[i-1];
            in_flight_q  <= in_flight_d;
            fifo_count_q <= fifo_count_d;
            if (cap) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock)
        if (cap) mem_q[wr_ptr_q] <= {trk_q[RESULT_LATENCY-1][TW-1:0], mul_R_high, mul_R_low};

    always_ff @(posedge clock)
        if (reset_n) assert (!(cap && fifo_count_q == CW'(FIFO_DEPTH)));

    assign {res_tag, res_high, res_low} = res_valid ? mem_q[rd_ptr_q] : '0;
    assign mul_config_addr   = CONFIG_ADDR_WIDTH'(CONFIG_ADDR);
    assign mul_config_signed = sgn_q;
    assign mul_config_enable = wr_q;
    assign mul_A_wren        = wr_q;
    assign mul_B_wren        = wr_q;
    assign mul_A             = a_q;
    assign mul_B             = b_q;
endmodule

// File: tb/tb_multiplier_slot_scheduler.sv
// tb_multiplier_slot_scheduler: directed bench with a behavioural thread-slotted multiplier behind the scheduler.
module tb_multiplier_slot_scheduler;
    localparam int W = 36, N = 4, L = 16;

    logic           clock = 1'b0, reset_n = 1'b0;
    logic [7:0]     slot_mask = 8'hFF;
    logic [N-1:0]   req_valid = '0, req_signed = '0, req_ready;
    logic [N*W-1:0] req_A = '0, req_B = '0;
    logic [0:0]     mul_config_addr;
    logic           mul_config_signed, mul_config_enable, mul_A_wren, mul_B_wren;
    logic [W-1:0]   mul_A, mul_B, mul_R_low, mul_R_high, res_low, res_high;
    logic           res_valid, res_ready = 1'b0;
    logic [1:0]     res_tag;
    logic [2*W-1:0] pipe [L];
    logic [2:0]     bslot;
    int             checks = 0, errors = 0;

    always #5 clock = ~clock;

    multiplier_slot_scheduler dut (
        .clock(clock), .reset_n(reset_n), .slot_mask(slot_mask),
        .req_valid(req_valid), .req_ready(req_ready), .req_A(req_A), .req_B(req_B),
        .req_signed(req_signed), .mul_config_addr(mul_config_addr),
        .mul_config_signed(mul_config_signed), .mul_config_enable(mul_config_enable),
        .mul_A(mul_A), .mul_B(mul_B), .mul_A_wren(mul_A_wren), .mul_B_wren(mul_B_wren),
        .mul_R_low(mul_R_low), .mul_R_high(mul_R_high), .res_valid(res_valid),
        .res_ready(res_ready), .res_tag(res_tag), .res_low(res_low), .res_high(res_high)
    );

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        return s ? $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b})
                 : {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Multiplier pipeline: a product written this cycle appears on mul_R_* L cycles later.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
            bslot <= '0;
        end else begin
            pipe[0] <= mul_A_wren ? prod(mul_A, mul_B, mul_config_signed) : '0;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            bslot <= bslot + 3'd1;
        end
    assign mul_R_low  = pipe[L-1][W-1:0];
    assign mul_R_high = pipe[L-1][2*W-1:W];

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pop(input string tag, input logic [1:0] etag, input logic [W-1:0] elow, input logic [W-1:0] ehigh);
        int n = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 40) begin
            tick;
            n++;
        end
        check({tag, "_valid"}, W'(res_valid), W'(1));
        check({tag, "_tag"}, W'(res_tag), W'(etag));
        check({tag, "_low"}, res_low, elow);
        check({tag, "_high"}, res_high, ehigh);
        tick;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] q [$];
        logic [1:0]   exp_t [4];
        logic         g;
        int           cnt, seen;
`ifdef MULT_SCHED_ROUND_ROBIN_EN
        exp_t = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
        exp_t = '{default: 2'd0};
`endif
        req_valid = 4'hF;
        repeat (3) tick;
        check("rst_req_ready", W'(req_ready), W'(0));
        check("rst_wren", W'({mul_A_wren, mul_B_wren, mul_config_enable, mul_config_signed}), W'(0));
        check("rst_mul_A", mul_A, '0);
        check("rst_mul_B", mul_B, '0);
        check("rst_res", W'({res_valid, res_tag}), W'(0));
        check("rst_res_data", res_low | res_high, '0);
        check("cfg_addr", W'(mul_config_addr), W'(0));
        req_valid = '0;
        reset_n = 1'b1;

        // single unsigned request from requester 2
        req_A[2*W +: W] = W'(7);
        req_B[2*W +: W] = W'(6);
        req_valid = 4'b0100;
        #1;
        check("t1_ready", W'(req_ready), W'(4'b0100));
        tick;
        req_valid = '0;
        check("t1_wren", W'({mul_A_wren, mul_B_wren, mul_config_enable}), W'(3'b111));
        check("t1_A", mul_A, W'(7));
        check("t1_B", mul_B, W'(6));
        check("t1_signed", W'(mul_config_signed), W'(0));
        repeat (16) tick;
        check("t1_early", W'(res_valid), W'(0));
        tick;
        check("t1_on_time", W'(res_valid), W'(1));
        expect_pop("t1", 2'd2, W'(42), '0);
        check("t1_popped", W'(res_valid), W'(0));

        // signed: -3 * 5 from requester 3
        req_A[3*W +: W] = ~W'(2);
        req_B[3*W +: W] = W'(5);
        req_signed = 4'b1000;
        req_valid = 4'b1000;
        #1;
        check("t2_ready", W'(req_ready), W'(4'b1000));
        tick;
        req_valid = '0;
        req_signed = '0;
        check("t2_signed", W'(mul_config_signed), W'(1));
        check("t2_A", mul_A, ~W'(2));
        expect_pop("t2", 2'd3, ~W'(14), '1);

        // requesters 0 and 1 contend for four grants
        req_A[0 +: W] = W'(3);
        req_B[0 +: W] = W'(4);
        req_A[W +: W] = W'(5);
        req_B[W +: W] = W'(5);
        req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("t3_grant%0d", k), W'(req_ready), W'(4'b0001 << exp_t[k]));
            tick;
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++)
            expect_pop($sformatf("t3_res%0d", k), exp_t[k], exp_t[k] == 2'd1 ? W'(25) : W'(12), '0);

        // only slots 0 and 2 usable
        slot_mask = 8'b0000_0101;
        res_ready = 1'b0;
        a = W'(10);
        req_A[0 +: W] = a;
        req_B[0 +: W] = W'(2);
        req_valid = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            #1;
            g = req_ready[0];
            check("t4_ready", W'(req_ready), W'(bslot == 3'd7 || bslot == 3'd1));
            if (k > 0) check("t4_wren", W'(mul_A_wren), W'(bslot == 3'd0 || bslot == 3'd2));
            if (k > 0 && mul_A_wren) check("t4_A", mul_A, q[$]);
            tick;
            if (g) begin
                q.push_back(a);
                a++;
                req_A[0 +: W] = a;
            end
        end
        req_valid = '0;
        check("t4_count", W'(q.size()), W'(4));
        for (int k = 0; k < q.size(); k++)
            expect_pop($sformatf("t4_res%0d", k), 2'd0, q[k] << 1, '0);

        // backpressure: credit limits grants to the FIFO depth
        slot_mask = 8'hFF;
        res_ready = 1'b0;
        q.delete();
        a = W'(100);
        req_A[0 +: W] = a;
        req_B[0 +: W] = W'(3);
        req_valid = 4'b0001;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            g = req_ready[0];
            cnt += int'(g);
            tick;
            if (g) begin
                q.push_back(a);
                a++;
                req_A[0 +: W] = a;
            end
        end
        check("t5_grants", W'(cnt), W'(8));
        check("t5_blocked", W'(req_ready), W'(0));
        expect_pop("t5_res0", 2'd0, W'(q[0] * W'(3)), '0);
        g = req_ready[0];
        check("t5_resume", W'(req_ready), W'(4'b0001));
        expect_pop("t5_res1", 2'd0, W'(q[1] * W'(3)), '0);
        req_valid = '0;
        if (g) q.push_back(a);
        check("t5_total", W'(q.size()), W'(9));
        for (int k = 2; k < q.size(); k++)
            expect_pop($sformatf("t5_res%0d", k), 2'd0, W'(q[k] * W'(3)), '0);
        check("t5_empty", W'(res_valid), W'(0));

        // reset with three results in flight
        req_A[0 +: W] = W'(11);
        req_B[0 +: W] = W'(11);
        req_valid = 4'b0001;
        repeat (3) tick;
        req_valid = '0;
        repeat (3) tick;
        check("t6_pre_A", mul_A, W'(11));
        reset_n = 1'b0;
        #1;
        check("t6_rst_A", mul_A, '0);
        check("t6_rst_B", mul_B, '0);
        check("t6_rst_ctl", W'({req_ready, mul_A_wren, mul_B_wren, mul_config_enable, mul_config_signed, res_valid}), W'(0));
        check("t6_rst_res", W'({res_tag, res_low | res_high}), W'(0));
        tick;
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            seen += int'(res_valid);
            tick;
        end
        check("t6_no_stale", W'(seen), W'(0));
        req_A[W +: W] = W'(9);
        req_B[W +: W] = W'(9);
        req_valid = 4'b0010;
        #1;
        check("t6_ready", W'(req_ready), W'(4'b0010));
        tick;
        req_valid = '0;
        expect_pop("t6_new", 2'd1, W'(81), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
